// File: rtl/tl_ul_sram_responder_if.sv
// TileLink-UL A/D channel bundle for a 32-bit link.
// slave:  the responder endpoint (drives a_ready and all d_* fields).
// master: the initiator side (drives a_* fields and d_ready).
interface tl_ul_sram_responder_if;
    logic        a_ready;
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [3:0]  a_size;
    logic [6:0]  a_source;
    logic [29:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        a_corrupt;

    logic        d_ready;
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic [6:0]  d_source;
    logic        d_sink;
    logic        d_denied;
    logic [31:0] d_data;
    logic        d_corrupt;

    modport slave (
        output a_ready,
        input  a_valid, a_opcode, a_param, a_size, a_source,
        input  a_address, a_mask, a_data, a_corrupt,
        input  d_ready,
        output d_valid, d_opcode, d_param, d_size, d_source,
        output d_sink, d_denied, d_data, d_corrupt
    );

    modport master (
        input  a_ready,
        output a_valid, a_opcode, a_param, a_size, a_source,
        output a_address, a_mask, a_data, a_corrupt,
        output d_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source,
        input  d_sink, d_denied, d_data, d_corrupt
    );
endinterface

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL responder backed by a word-addressed register array.
// Requests are decoded and executed on the accept edge; the response is
// queued in a 2-entry FIFO and presented on the D channel from its head.
// a_ready is derived from the registered FIFO count only, so there is no
// combinational path from d_ready or a_valid to a_ready.
module tl_ul_sram_responder #(
    parameter int          DEPTH     = 256,
    parameter logic [29:0] BASE_ADDR = 30'h0
) (
    input  logic                    clock,
    input  logic                    reset,
    tl_ul_sram_responder_if.slave   tl
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [2:0]  opcode;
        logic [3:0]  size;
        logic [6:0]  source;
        logic        denied;
        logic        corrupt;
        logic [31:0] data;
    } rsp_t;

    // Memory array is intentionally not reset so contents survive reset.
    logic [31:0] r_mem [DEPTH];
    rsp_t        r_fifo [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    logic [AW-1:0] w_idx;
    logic          w_in_range;
    logic          w_op_ok;
    logic          w_aligned;
    logic          w_is_get;
    logic          w_denied;
    logic          w_a_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_wr_en;
    rsp_t          w_rsp;
    rsp_t          w_head;

    assign w_a_ready = reset & (r_count != 2'd2);
    assign w_push    = tl.a_valid & w_a_ready;
    assign w_pop     = (r_count != 2'd0) & tl.d_ready;
    assign w_head    = r_fifo[r_rd_ptr];

    // Request decode: word index, range/opcode/size/alignment legality.
    always_comb begin
        w_idx      = tl.a_address[AW+1:2];
        w_in_range = (tl.a_address[29:AW+2] == BASE_ADDR[29:AW+2]);
        w_is_get   = (tl.a_opcode == 3'd4);
        w_op_ok    = (tl.a_opcode == 3'd0) | (tl.a_opcode == 3'd1) | w_is_get;
        case (tl.a_size)
            4'd0:    w_aligned = 1'b1;
            4'd1:    w_aligned = ~tl.a_address[0];
            4'd2:    w_aligned = (tl.a_address[1:0] == 2'b00);
            default: w_aligned = 1'b0;
        endcase
        w_denied = ~w_in_range | ~w_op_ok | ~w_aligned;
        // Poisoned write data still gets a normal ack, just no store.
        w_wr_en  = w_push & ~w_is_get & ~w_denied & ~tl.a_corrupt;

        w_rsp         = '0;
        w_rsp.opcode  = w_is_get ? 3'd1 : 3'd0;
        w_rsp.size    = tl.a_size;
        w_rsp.source  = tl.a_source;
        w_rsp.denied  = w_denied;
        w_rsp.corrupt = w_is_get & w_denied;
        w_rsp.data    = (w_is_get & ~w_denied) ? r_mem[w_idx] : 32'h0;
    end

    // Byte-lane write on the accept edge, so a Get on the next cycle sees it.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (tl.a_mask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= tl.a_data[8*b +: 8];
                end
            end
        end
    end

    // Response FIFO; reset flushes pending entries and clears the head.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_fifo[0] <= '0;
            r_fifo[1] <= '0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_rsp;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign tl.a_ready   = w_a_ready;
    assign tl.d_valid   = (r_count != 2'd0);
    assign tl.d_opcode  = w_head.opcode;
    assign tl.d_param   = 2'd0;
    assign tl.d_size    = w_head.size;
    assign tl.d_source  = w_head.source;
    assign tl.d_sink    = 1'b0;
    assign tl.d_denied  = w_head.denied;
    assign tl.d_data    = w_head.data;
    assign tl.d_corrupt = w_head.corrupt;
endmodule

// File: doc/tl_ul_sram_responder.md
# tl_ul_sram_responder

TileLink-UL responder (slave endpoint) for a 32-bit wide link. It terminates the A channel, services Get, PutFullData and PutPartialData against an internal word-addressed register array, and returns in-order AccessAck/AccessAckData responses on the D channel. It sits at the far end of the pass-through TileLink adapters and gives the initiator side a concrete target for bring-up and verification.

## Interface
Parameters:
- `DEPTH`, 256: number of 32-bit words; power of two, 2..4096.
- `BASE_ADDR`, 30'h0: byte base address; aligned to `DEPTH*4`.

Ports:
- `clock`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `a_ready`  out  1  A-channel ready.
- `a_valid`  in  1  A-channel valid.
- `a_opcode`  in  3  0 PutFullData, 1 PutPartialData, 4 Get.
- `a_param`  in  3  ignored.
- `a_size`  in  4  log2 bytes.
- `a_source`  in  7  request ID.
- `a_address`  in  30  byte address.
- `a_mask`  in  4  byte lanes.
- `a_data`  in  32  write data.
- `a_corrupt`  in  1  write data poisoned.
- `d_ready`  in  1  D-channel ready.
- `d_valid`  out  1  D-channel valid.
- `d_opcode`  out  3  0 AccessAck, 1 AccessAckData.
- `d_param`  out  2  always 0.
- `d_size`  out  4  echoes `a_size`.
- `d_source`  out  7  echoes `a_source`.
- `d_sink`  out  1  always 0.
- `d_denied`  out  1  request refused.
- `d_data`  out  32  read data; 0 unless AccessAckData and not denied.
- `d_corrupt`  out  1  set only with denied AccessAckData.

## Operation
- A beat is accepted on an edge with `a_valid & a_ready`. One beat per request; UL only, no bursts.
- Word index is `a_address[log2(DEPTH)+1:2]`. A request is in range when `a_address[29:log2(DEPTH)+2]` equals the matching bits of `BASE_ADDR`.
- The request is denied when it is out of range, `a_size > 2`, the opcode is not 0, 1 or 4, or the address is misaligned to `a_size`. A denied request has no memory side effect.
  - Denied Get returns AccessAckData with `d_denied=1`, `d_corrupt=1` and `d_data=0`.
  - Denied Put returns AccessAck with `d_denied=1`.
- Put (0 or 1): on the accept edge, bytes whose `a_mask` bit is set are written. If `a_corrupt=1`, the write is suppressed and a normal AccessAck is still returned.
- Get: on the accept edge, the full addressed word is captured into the response. `d_data` is returned unmasked.
- Responses go into a 2-entry FIFO holding opcode, size, source, denied, corrupt and data. `d_*` is driven from the FIFO head. An entry pops on `d_valid & d_ready`.
- `a_ready = reset & (count < 2)`. `a_ready` depends only on registered count, with no combinational path from `d_ready` or `a_valid`.
- Simultaneous push and pop: count is unchanged and the head advances. Push is legal at count 1 with a pop on the same edge.
- Read after write is ordered: a Get accepted in the cycle after a Put to the same word returns the new data. The memory write lands on the Put accept edge.
- `d_*` fields hold stable while `d_valid & !d_ready`.
- Memory array is not reset; contents persist across reset.

## Timing
- Reset values: `d_valid=0`, `a_ready=0` while reset is asserted and 1 in the first cycle after deassertion, FIFO count 0. Other `d_*` outputs are 0 (head entry cleared).
- Latency: a beat accepted at edge N appears with `d_valid=1` after edge N (cycle N+1) when the FIFO was empty.
- Throughput: 1 request per cycle with `d_ready` held high.
- Backpressure: with `d_ready=0`, at most 2 requests are accepted, then `a_ready` drops. `a_ready` rises the cycle after the first pop.
- Reset mid-operation: FIFO is flushed and pending responses are dropped without emission. A write accepted before the reset edge remains in memory.

## Test plan
- Put then Get: PutFullData addr `BASE+0x10`, mask 0xF, data 0xDEADBEEF, then Get same address → AccessAck, then AccessAckData with data 0xDEADBEEF. Source IDs are echoed and the Get response arrives 1 cycle after accept.
- Partial write: PutPartialData mask 0x5, data 0x11223344 over 0xDEADBEEF → subsequent Get returns 0xDE22BE44.
- Deny cases, each with no memory change on re-read:
  - Get at `BASE+DEPTH*4` → AccessAckData, denied=1, corrupt=1, data 0.
  - Get with `a_size=3` → AccessAckData, denied=1, corrupt=1, data 0.
  - Opcode 2 → AccessAck, denied=1.
  - Put with `a_size=1`, address offset 1 → AccessAck, denied=1.
- Backpressure: `d_ready=0` while 3 Gets are offered → exactly 2 accepted and `a_ready=0` from the next cycle. Raising `d_ready` drains in order, with sources 1, 2, 3.
- Streaming: 16 back-to-back Gets with `d_ready=1` → 16 consecutive `d_valid` cycles. Insert a push and pop on the same edge at count 1 → no lost or duplicated response.
- Reset mid-flight: 2 responses queued, pulse `reset` low one cycle → `d_valid=0` and the queued responses are never emitted. A Get of a pre-reset written word returns the written data.
